is_uart_loopback_fifo: RTL and testbench

//   Buffers received UART bytes and returns them to the transmitter (echo/loopback path).

---
 rtl/is_uart_loopback_fifo.sv | 99 +++++++++
 tb/tb_is_uart_loopback_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/is_uart_loopback_fifo.sv
// Echo path between the UART receiver and transmitter: buffers received bytes,
// filters corrupted frames, counts receive errors and flags lost bytes.
module is_uart_loopback_fifo #(
  parameter int DEPTH    = 16,
  parameter int ERR_W    = 8,
  parameter bit DROP_ERR = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         rx_data_en_i,
  input  logic [9:0]                   rx_data_t_i,
  output logic                         tx_rdy_t_o,
  output logic [7:0]                   tx_data_r_o,
  input  logic                         tx_rdy_r_i,
  output logic [$clog2(DEPTH+1)-1:0]   fill_o,
  output logic [ERR_W-1:0]             err_cnt_o,
  output logic                         ovf_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH+1);
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic [7:0]        head_nxt;
  logic              rx_err;
  logic              accept;
  logic              full;
  logic              pop;
  logic              push;
  logic              lost;

  always_comb begin
    rx_err = rx_data_en_i & (rx_data_t_i[8] | rx_data_t_i[9]);
    accept = rx_data_en_i & ~(rx_err & DROP_ERR);
    full   = (fill_o == FULL_LVL);
    pop    = tx_rdy_t_o & tx_rdy_r_i;
    push   = accept & (~full | pop);
    lost   = accept & full & ~pop;
  end

  always_comb begin
    wr_ptr_nxt = push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_nxt = pop  ? rd_ptr + 1'b1 : rd_ptr;
    fill_nxt   = fill_o;
    case ({push, pop})
      2'b10:   fill_nxt = fill_o + 1'b1;
      2'b01:   fill_nxt = fill_o - 1'b1;
      default: fill_nxt = fill_o;
    endcase
    // The incoming byte becomes the new head when it lands where the read pointer is heading,
    // which lets an empty FIFO present a byte one edge after it arrives.
    if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = rx_data_t_i[7:0];
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= rx_data_t_i[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_o      <= '0;
      tx_rdy_t_o  <= 1'b0;
      tx_data_r_o <= '0;
      err_cnt_o   <= '0;
      ovf_o       <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      fill_o     <= fill_nxt;
      tx_rdy_t_o <= (fill_nxt != '0);
      // Head register holds its last value while the FIFO sits empty.
      if (fill_nxt != '0) begin
        tx_data_r_o <= head_nxt;
      end
      if (rx_err && (err_cnt_o != ERR_MAX)) begin
        err_cnt_o <= err_cnt_o + 1'b1;
      end
      if (lost) begin
        ovf_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_is_uart_loopback_fifo.sv
// Randomized and directed bench for is_uart_loopback_fifo, checked against a
// queue-based model of the loopback FIFO.
module tb_is_uart_loopback_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_en;
  logic [9:0] rx_data;
  logic       tx_rdy_t;
  logic [7:0] tx_data;
  logic       tx_rdy_r;
  logic [4:0] fill;
  logic [7:0] err_cnt;
  logic       ovf;

  logic       b_rx_en;
  logic [9:0] b_rx_data;
  logic       b_tx_rdy_t;
  logic [7:0] b_tx_data;
  logic       b_tx_rdy_r;
  logic [4:0] b_fill;
  logic [7:0] b_err_cnt;
  logic       b_ovf;

  int         assertCount = 0;
  int         failCount   = 0;
  logic [7:0] modelQ[$];
  logic [7:0] acceptedQ[$];
  logic [7:0] observedQ[$];
  int         modelErr;
  logic       modelOvf;

  always #5 clk = ~clk;

  is_uart_loopback_fifo #(.DEPTH(DEPTH), .ERR_W(8), .DROP_ERR(1'b1)) dut (
    .clk_i(clk), .rstn_i(rstn), .rx_data_en_i(rx_en), .rx_data_t_i(rx_data),
    .tx_rdy_t_o(tx_rdy_t), .tx_data_r_o(tx_data), .tx_rdy_r_i(tx_rdy_r),
    .fill_o(fill), .err_cnt_o(err_cnt), .ovf_o(ovf)
  );

  is_uart_loopback_fifo #(.DEPTH(DEPTH), .ERR_W(8), .DROP_ERR(1'b0)) dutKeep (
    .clk_i(clk), .rstn_i(rstn), .rx_data_en_i(b_rx_en), .rx_data_t_i(b_rx_data),
    .tx_rdy_t_o(b_tx_rdy_t), .tx_data_r_o(b_tx_data), .tx_rdy_r_i(b_tx_rdy_r),
    .fill_o(b_fill), .err_cnt_o(b_err_cnt), .ovf_o(b_ovf)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " fill"}, 32'(fill), 32'(modelQ.size()));
    checkVal({tag, " tx_rdy_t"}, 32'(tx_rdy_t), 32'(modelQ.size() != 0));
    if (modelQ.size() != 0) checkVal({tag, " tx_data"}, 32'(tx_data), 32'(modelQ[0]));
    checkVal({tag, " err_cnt"}, 32'(err_cnt), 32'(modelErr));
    checkVal({tag, " ovf"}, 32'(ovf), 32'(modelOvf));
  endtask

  // One clock of stimulus on the main instance; the model applies the
  // behavioural rules with the state it held before the edge.
  task automatic applyStimulus(input logic en, input logic [9:0] data, input logic rdy);
    int   sizeBefore;
    logic doPop;
    logic err;
    sizeBefore = modelQ.size();
    doPop      = (sizeBefore != 0) && rdy;
    err        = en && (data[8] || data[9]);
    rx_en      = en;
    rx_data    = data;
    tx_rdy_r   = rdy;
    if (tx_rdy_t && rdy) observedQ.push_back(tx_data);
    if (err && modelErr < 255) modelErr++;
    if (doPop) void'(modelQ.pop_front());
    if (en && !err) begin
      if (sizeBefore < DEPTH || doPop) begin
        modelQ.push_back(data[7:0]);
        acceptedQ.push_back(data[7:0]);
      end else begin
        modelOvf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    rx_en    = 1'b0;
    tx_rdy_r = 1'b0;
  endtask

  task automatic doReset();
    rstn     = 1'b0;
    rx_en    = 1'b0;
    tx_rdy_r = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    modelQ.delete();
    modelErr = 0;
    modelOvf = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    rx_en      = 1'b0;
    rx_data    = '0;
    tx_rdy_r   = 1'b0;
    b_rx_en    = 1'b0;
    b_rx_data  = '0;
    b_tx_rdy_r = 1'b0;
    modelErr   = 0;
    modelOvf   = 1'b0;
    @(posedge clk);
    doReset();
    checkVal("reset fill", 32'(fill), 0);
    checkVal("reset tx_rdy_t", 32'(tx_rdy_t), 0);
    checkVal("reset tx_data", 32'(tx_data), 0);
    checkVal("reset err_cnt", 32'(err_cnt), 0);
    checkVal("reset ovf", 32'(ovf), 0);

    $display("[TB] single byte");
    applyStimulus(1'b1, 10'h041, 1'b0);
    checkVal("t1 tx_data", 32'(tx_data), 32'h41);
    checkVal("t1 fill", 32'(fill), 1);
    checkOutput("t1 queued");
    applyStimulus(1'b0, 10'h000, 1'b1);
    checkVal("t1 drained", 32'(tx_rdy_t), 0);
    checkOutput("t1 empty");

    $display("[TB] error filter");
    b_rx_en = 1'b1;
    b_rx_data = 10'h155;
    applyStimulus(1'b1, 10'h155, 1'b0);
    b_rx_data = 10'h2AA;
    applyStimulus(1'b1, 10'h2AA, 1'b0);
    b_rx_en = 1'b0;
    checkVal("t2 drop fill", 32'(fill), 0);
    checkVal("t2 drop err_cnt", 32'(err_cnt), 2);
    checkOutput("t2 drop");
    checkVal("t2 keep fill", 32'(b_fill), 2);
    checkVal("t2 keep head0", 32'(b_tx_data), 32'h55);
    checkVal("t2 keep err_cnt", 32'(b_err_cnt), 2);
    b_tx_rdy_r = 1'b1;
    applyStimulus(1'b0, 10'h000, 1'b0);
    checkVal("t2 keep head1", 32'(b_tx_data), 32'hAA);
    applyStimulus(1'b0, 10'h000, 1'b0);
    b_tx_rdy_r = 1'b0;
    checkVal("t2 keep empty", 32'(b_fill), 0);

    $display("[TB] overflow");
    for (int i = 0; i <= 16; i++) applyStimulus(1'b1, 10'(i), 1'b0);
    checkVal("t3 fill", 32'(fill), 16);
    checkVal("t3 ovf", 32'(ovf), 1);
    checkOutput("t3 full");
    for (int i = 0; i < 16; i++) begin
      checkVal("t3 drain order", 32'(tx_data), 32'(i));
      applyStimulus(1'b0, 10'h000, 1'b1);
      checkOutput("t3 drain");
    end
    checkVal("t3 drained", 32'(fill), 0);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 260; i++) applyStimulus(1'b1, 10'h100 | 10'(i[7:0]), 1'b0);
    checkVal("sat err_cnt", 32'(err_cnt), 255);
    checkOutput("sat");

    doReset();
    $display("[TB] full with simultaneous pop");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 10'h020 + 10'(i), 1'b0);
    applyStimulus(1'b1, 10'h0EE, 1'b1);
    checkVal("t4 fill", 32'(fill), 16);
    checkVal("t4 ovf", 32'(ovf), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) checkVal("t4 last", 32'(tx_data), 32'hEE);
      applyStimulus(1'b0, 10'h000, 1'b1);
      checkOutput("t4 drain");
    end

    $display("[TB] random back-pressure");
    acceptedQ.delete();
    observedQ.delete();
    begin
      int sent;
      logic en;
      logic [9:0] data;
      sent = 0;
      for (int cyc = 0; cyc < 300 && sent < 40; cyc++) begin
        en   = ($urandom_range(0, 2) != 0);
        data = {2'b00, 8'($urandom)};
        if (en) sent++;
        applyStimulus(en, data, 1'($urandom_range(0, 1)));
        checkOutput("t5 step");
        checkVal("t5 fill bound", 32'(fill <= 5'd16), 1);
      end
      for (int cyc = 0; cyc < 20; cyc++) applyStimulus(1'b0, 10'h000, 1'b1);
      checkOutput("t5 drained");
      checkVal("t5 stream length", 32'(observedQ.size()), 32'(acceptedQ.size()));
      for (int i = 0; i < acceptedQ.size() && i < observedQ.size(); i++)
        checkVal("t5 stream byte", 32'(observedQ[i]), 32'(acceptedQ[i]));
    end

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 10'h3FF, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 10'h060 + 10'(i), 1'b0);
    checkVal("t6 fill", 32'(fill), 5);
    checkVal("t6 err before", 32'(err_cnt), 1);
    doReset();
    checkVal("t6 fill", 32'(fill), 0);
    checkVal("t6 tx_rdy_t", 32'(tx_rdy_t), 0);
    checkVal("t6 err_cnt", 32'(err_cnt), 0);
    checkVal("t6 ovf", 32'(ovf), 0);
    applyStimulus(1'b1, 10'h099, 1'b0);
    checkVal("t6 first byte", 32'(tx_data), 32'h99);
    checkOutput("t6 after");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
